// File: rtl/horner_poly_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : horner_poly_pipe_if
//  Description : Sample stream, result stream and coefficient-config bundle
//                for the Horner polynomial pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
interface horner_poly_pipe_if #(
  parameter int WIDTHIN  = 16,
  parameter int WIDTHOUT = 32
) ();

  // upstream sample stream
  logic                i_valid;
  logic                o_ready;
  logic [WIDTHIN-1:0]  i_x;

  // downstream result stream
  logic                o_valid;
  logic                i_ready;
  logic [WIDTHOUT-1:0] o_y;

  // coefficient programming
  logic                cfg_we;
  logic [3:0]          cfg_addr;
  logic [WIDTHIN-1:0]  cfg_data;
  logic                cfg_err;

  // status
  logic                o_busy;

  // driver side: sample source, result sink and configuration master
  modport master (
    output i_valid, i_x, i_ready, cfg_we, cfg_addr, cfg_data,
    input  o_ready, o_valid, o_y, cfg_err, o_busy
  );

  // pipeline side
  modport slave (
    input  i_valid, i_x, i_ready, cfg_we, cfg_addr, cfg_data,
    output o_ready, o_valid, o_y, cfg_err, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/horner_poly_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : horner_poly_pipe
//  Description : ORDER-degree unsigned fixed-point polynomial evaluator using
//                Horner's rule, one MAC per stage, one sample per clock, with
//                programmable coefficients, optional saturation and full
//                valid/ready backpressure with bubble collapsing.
//  Revision    : 1.0 - initial release
// ============================================================================
module horner_poly_pipe #(
  parameter int WIDTHIN  = 16,
  parameter int IN_FRAC  = 14,
  parameter int WIDTHOUT = 32,
  parameter int OUT_FRAC = 25,
  parameter int ORDER    = 5,
  parameter int SAT      = 1,
  parameter logic [(ORDER+1)*WIDTHIN-1:0] COEF_INIT =
    96'h0088_02AA_0AAA_2000_4000_4000
) (
  input  wire                      clk,
  input  wire                      reset_n,
  horner_poly_pipe_if.slave        bus
);

  // Coefficients are aligned to the accumulator's binary point by this shift.
  localparam int SH = OUT_FRAC - IN_FRAC;
  // Full product width and one extra bit for the coefficient addition.
  localparam int PW = WIDTHOUT + WIDTHIN;
  localparam int EW = PW + 1;

  logic [WIDTHIN-1:0]  coef     [0:ORDER];
  logic [ORDER:0]      valid;
  logic [WIDTHIN-1:0]  xs       [0:ORDER-1];
  logic [WIDTHOUT-1:0] acc      [0:ORDER];
  logic [WIDTHOUT-1:0] acc_next [1:ORDER];
  logic [ORDER:0]      adv;
  logic [ORDER:0]      load;
  logic [WIDTHOUT-1:0] seed;
  logic [PW-1:0]       prod;
  logic [EW-1:0]       sum;
  logic                accept;
  logic                busy;
  logic                cfg_ok;
  logic                cfg_err_q;

  // Advance chain from the output back to stage 0: a stage moves on when the
  // next one is empty or moving itself, so bubbles are squeezed out.
  always_comb begin
    adv        = '0;
    load       = '0;
    adv[ORDER] = valid[ORDER] & bus.i_ready;
    for (int k = ORDER - 1; k >= 0; k--) begin
      adv[k] = valid[k] & (~valid[k+1] | adv[k+1]);
    end
    load = ~valid | adv;
  end

  assign seed      = WIDTHOUT'(coef[ORDER]) << SH;
  assign accept    = bus.i_valid & load[0];
  assign busy      = |valid;

  // A write is only safe when nothing is in flight and nothing enters now,
  // otherwise a sample could see a mix of old and new coefficients.
  assign cfg_ok    = bus.cfg_we & ~busy & ~accept & (bus.cfg_addr <= 4'(ORDER));

  assign bus.o_ready = load[0];
  assign bus.o_valid = valid[ORDER];
  assign bus.o_y     = acc[ORDER];
  assign bus.o_busy  = busy;
  assign bus.cfg_err = cfg_err_q;

  // Per-stage multiply-accumulate: truncate the product back to the
  // accumulator's scaling, add the aligned coefficient, then clamp or wrap.
  always_comb begin
    prod = '0;
    sum  = '0;
    for (int k = 1; k <= ORDER; k++) begin
      acc_next[k] = '0;
    end
    for (int k = 1; k <= ORDER; k++) begin
      prod = PW'(acc[k-1]) * PW'(xs[k-1]);
      sum  = EW'(prod >> IN_FRAC) + (EW'(coef[ORDER-k]) << SH);
      if ((|sum[EW-1:WIDTHOUT]) && (SAT != 0)) begin
        acc_next[k] = '1;
      end else begin
        acc_next[k] = sum[WIDTHOUT-1:0];
      end
    end
  end

  // Pipeline registers: a loading stage takes the previous stage's contents,
  // a stalled stage holds everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      for (int k = 0; k < ORDER; k++) begin
        xs[k] <= '0;
      end
      for (int k = 0; k <= ORDER; k++) begin
        acc[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid[0] <= accept;
        if (accept) begin
          xs[0]  <= bus.i_x;
          acc[0] <= seed;
        end
      end
      for (int k = 1; k <= ORDER; k++) begin
        if (load[k]) begin
          valid[k] <= valid[k-1];
          if (valid[k-1]) begin
            acc[k] <= acc_next[k];
          end
        end
      end
      // The last stage needs no x, so x only travels up to stage ORDER-1.
      for (int k = 1; k < ORDER; k++) begin
        if (load[k] && valid[k-1]) begin
          xs[k] <= xs[k-1];
        end
      end
    end
  end

  // Coefficient store and one-cycle rejection pulse for refused writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= ORDER; i++) begin
        coef[i] <= COEF_INIT[i*WIDTHIN +: WIDTHIN];
      end
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_we & ~cfg_ok;
      for (int i = 0; i <= ORDER; i++) begin
        if (cfg_ok && (bus.cfg_addr == 4'(i))) begin
          coef[i] <= bus.cfg_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_horner_poly_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_horner_poly_pipe
//  Description : Directed and streaming self-checking bench for
//                horner_poly_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_horner_poly_pipe #(
  parameter int ORDER = 5,
  parameter int SAT   = 1
);

  localparam int WIN  = 16;
  localparam int WOUT = 32;
  localparam int IFR  = 14;
  localparam int OFR  = 25;
  localparam int SH   = OFR - IFR;
  localparam int NC   = ORDER + 1;

  // e^x Taylor set: c[i] = trunc(1.0 / i!) in Q2.14
  function automatic logic [NC*WIN-1:0] taylor_init();
    logic [NC*WIN-1:0] v;
    int f;
    v = '0;
    f = 1;
    for (int i = 0; i < NC; i++) begin
      if (i > 0 && f <= 16384) f = f * i;
      v[i*WIN +: WIN] = 16'(16384 / f);
    end
    return v;
  endfunction

  localparam logic [NC*WIN-1:0] INIT = taylor_init();

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_miss;
  logic [15:0] coef [0:15];

  horner_poly_pipe_if #(.WIDTHIN(WIN), .WIDTHOUT(WOUT)) bus ();

  horner_poly_pipe #(
    .WIDTHIN  (WIN),
    .IN_FRAC  (IFR),
    .WIDTHOUT (WOUT),
    .OUT_FRAC (OFR),
    .ORDER    (ORDER),
    .SAT      (SAT),
    .COEF_INIT(INIT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: Horner evaluation with truncating rescale and clamp/wrap.
  function automatic logic [31:0] model_y(input logic [15:0] xv);
    logic [63:0] a;
    a = 64'(coef[ORDER]) << SH;
    for (int k = 1; k <= ORDER; k++) begin
      a = ((a * 64'(xv)) >> IFR) + (64'(coef[ORDER-k]) << SH);
      if (a > 64'hFFFF_FFFF) a = (SAT != 0) ? 64'hFFFF_FFFF : (a & 64'hFFFF_FFFF);
    end
    return a[31:0];
  endfunction

  task automatic load_init_model();
    for (int i = 0; i < 16; i++) coef[i] = (i <= ORDER) ? INIT[i*WIN +: WIN] : 16'h0;
  endtask

  // Single sample through an idle pipe with the output always ready.
  task automatic run_one(input string tag, input logic [15:0] xv, input logic [31:0] exp_y);
    int cyc;
    logic rdy_ok;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_x     = xv;
    bus.i_ready = 1'b1;
    #1;
    check_val({tag, "_rdy"}, bus.o_ready, 1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    cyc    = 1;
    rdy_ok = 1'b1;
    while (!bus.o_valid && cyc < 64) begin
      if (!bus.o_ready) rdy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_lat"}, cyc, ORDER + 1);
    check_val({tag, "_y"}, bus.o_y, exp_y);
    check_val({tag, "_rdy_hold"}, rdy_ok, 1);
  endtask

  task automatic cfg_write(input string tag, input logic [3:0] a, input logic [15:0] d, input logic exp_err);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check_val(tag, bus.cfg_err, exp_err);
    if (!exp_err) coef[a] = d;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.o_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, bus.o_busy, 0);
  endtask

  initial begin
    logic [31:0] expq [$];
    logic [31:0] held_y;
    logic        hold;
    int sent, got, occ, cyc, stale, a, n;

    n_vec  = 0;
    n_miss = 0;
    load_init_model();
    reset_n      = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_x      = '0;
    bus.i_ready  = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;

    // reset state
    repeat (3) @(negedge clk);
    check_val("rst_valid", bus.o_valid, 0);
    check_val("rst_y", bus.o_y, 0);
    check_val("rst_err", bus.cfg_err, 0);
    check_val("rst_busy", bus.o_busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_ready", bus.o_ready, 1);

    // default coefficients: x = 0 gives c0 = 1.0, x = 1.0 gives the sum
    run_one("dflt_x0", 16'h0000, 32'h0200_0000);
    run_one("dflt_x1", 16'h4000, model_y(16'h4000));

    // identity polynomial y = x
    for (int i = 0; i <= ORDER; i++) cfg_write("lin_wr", 4'(i), (i == 1) ? 16'h4000 : 16'h0000, 1'b0);
    run_one("lin_half", 16'h2000, 32'h0100_0000);
    run_one("lin_one", 16'h4000, 32'h0200_0000);

    // write while a sample is in flight is refused
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_x     = 16'h0000;
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_valid  = 1'b0;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd1;
    bus.cfg_data = 16'h1234;
    #1;
    check_val("busy_flag", bus.o_busy, 1);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check_val("busy_err", bus.cfg_err, 1);
    @(negedge clk);
    check_val("err_pulse", bus.cfg_err, 0);
    wait_idle("busy_drain");
    run_one("busy_keep", 16'h4000, 32'h0200_0000);

    // out-of-range address
    a = (ORDER < 15) ? ORDER + 1 : 15;
    cfg_write("addr_err", 4'(a), 16'h5555, (a > ORDER));
    run_one("addr_keep", 16'h4000, model_y(16'h4000));

    // write in the same cycle as an accept is refused
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_x      = 16'h4000;
    bus.i_ready  = 1'b1;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'd1;
    bus.cfg_data = 16'h0000;
    #1;
    check_val("accwr_rdy", bus.o_ready, 1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.cfg_we  = 1'b0;
    check_val("accwr_err", bus.cfg_err, 1);
    n = 0;
    while (!bus.o_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_val("accwr_y", bus.o_y, model_y(16'h4000));
    run_one("accwr_keep", 16'h4000, model_y(16'h4000));

    // overflow
    for (int i = 0; i <= ORDER; i++) cfg_write("ovf_wr", 4'(i), 16'h7FFF, 1'b0);
    run_one("ovf", 16'hFFFF, model_y(16'hFFFF));

    // reset with samples in flight
    @(negedge clk);
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_valid = 1'b1;
      bus.i_x     = 16'(16'h1000 * (i + 1));
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    repeat (ORDER) @(negedge clk);
    check_val("pre_rst_valid", bus.o_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_valid", bus.o_valid, 0);
    check_val("mid_rst_busy", bus.o_busy, 0);
    check_val("mid_rst_y", bus.o_y, 0);
    repeat (2) @(negedge clk);
    reset_n     = 1'b1;
    bus.i_ready = 1'b1;
    stale = 0;
    repeat (2 * ORDER + 6) begin
      @(negedge clk);
      if (bus.o_valid) stale++;
    end
    check_val("stale_out", stale, 0);
    load_init_model();
    run_one("reinit_x0", 16'h0000, 32'h0200_0000);
    run_one("reinit_x1", 16'h4000, model_y(16'h4000));

    // streaming with backpressure and long full stalls
    sent = 0;
    got  = 0;
    occ  = 0;
    cyc  = 0;
    hold = 1'b0;
    held_y = '0;
    while (got < 40 && cyc < 3000) begin
      @(negedge clk);
      bus.i_valid = (sent < 40);
      bus.i_x     = 16'($urandom);
      if ((cyc >= 8 && cyc < 30) || (cyc >= 50 && cyc < 70)) bus.i_ready = 1'b0;
      else bus.i_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold) begin
        check_val("str_hold_v", bus.o_valid, 1);
        check_val("str_hold_y", bus.o_y, held_y);
      end
      hold   = bus.o_valid && !bus.i_ready;
      held_y = bus.o_y;
      check_val("str_rdy", bus.o_ready, !((occ == ORDER + 1) && !bus.i_ready));
      if (bus.o_valid && bus.i_ready) begin
        if (expq.size() == 0) check_val("str_extra", bus.o_valid, 0);
        else check_val("str_y", bus.o_y, expq.pop_front());
        got++;
        occ--;
      end
      if (bus.i_valid && bus.o_ready) begin
        expq.push_back(model_y(bus.i_x));
        sent++;
        occ++;
      end
      cyc++;
    end
    bus.i_valid = 1'b0;
    check_val("str_count", got, 40);
    check_val("str_left", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
